// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, sequencer state type
// and special-value helpers that work for any field width up to FP_MAXW bits.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_MAXW  = 64;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fp_state_e;

    function automatic logic fp_exp_ones(input logic [FP_MAXW-1:0] e, input int ew);
        return e == ((FP_MAXW'(1) << ew) - FP_MAXW'(1));
    endfunction

    function automatic logic fp_exp_zero(input logic [FP_MAXW-1:0] e);
        return e == '0;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [FP_MAXW-1:0] fp_qnan(input int ew, input int mw);
        return (((FP_MAXW'(1) << ew) - FP_MAXW'(1)) << mw) | (FP_MAXW'(1) << (mw - 1));
    endfunction

    function automatic logic [FP_MAXW-1:0] fp_inf(input logic s, input int ew, input int mw);
        return (FP_MAXW'(s) << (ew + mw)) | (((FP_MAXW'(1) << ew) - FP_MAXW'(1)) << mw);
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational back end: normalises the raw significand product, rounds to
// nearest-even and maps exponent overflow/underflow to infinity/zero.
module fp_round_norm
    import fp_pkg::*;
#(
    parameter  int EXP_W  = FP_EXP_W,
    parameter  int MAN_W  = FP_MAN_W,
    localparam int W      = 1 + EXP_W + MAN_W,
    localparam int SIG_W  = MAN_W + 1,
    localparam int PROD_W = 2 * SIG_W,
    localparam int XW     = EXP_W + 2
) (
    input  logic [PROD_W-1:0]    i_prod,
    input  logic signed [XW-1:0] i_exp,
    input  logic                 i_sign,
    output logic [W-1:0]         o_result,
    output logic                 o_of,
    output logic                 o_uf
);

    localparam logic signed [XW-1:0] EMAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EZERO = '0;

    logic                 w_top;
    logic [PROD_W-2:0]    w_sh;
    logic [MAN_W-1:0]     w_frac;
    logic [MAN_W-1:0]     w_frac_r;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    logic                 w_carry;
    logic signed [XW-1:0] w_exp;

    // Product of two [1,2) significands lies in [1,4): at most one right shift.
    assign w_top    = i_prod[PROD_W-1];
    assign w_sh     = w_top ? i_prod[PROD_W-2:0] : {i_prod[PROD_W-3:0], 1'b0};
    assign w_frac   = w_sh[PROD_W-2:SIG_W];
    assign w_guard  = w_sh[SIG_W-1];
    assign w_sticky = |w_sh[SIG_W-2:0];
    assign w_inc    = w_guard & (w_sticky | w_frac[0]);

    // A carry out leaves the fraction at zero, i.e. the significand became 2.0.
    assign {w_carry, w_frac_r} = {1'b0, w_frac} + (MAN_W+1)'(w_inc);
    assign w_exp = i_exp + XW'(w_top) + XW'(w_carry);

    always_comb begin
        o_of     = 1'b0;
        o_uf     = 1'b0;
        o_result = {i_sign, w_exp[EXP_W-1:0], w_frac_r};
        if (w_exp >= EMAX) begin
            o_of     = 1'b1;
            o_result = W'(fp_inf(i_sign, EXP_W, MAN_W));
        end else if (w_exp <= EZERO) begin
            o_uf     = 1'b1;
            o_result = {i_sign, {(W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_seq_multiplier.sv
// Sequential floating-point multiplier: one shift-and-add step per cycle, then
// a single normalise/round cycle. Special operands bypass straight to DONE.
module fp_seq_multiplier
    import fp_pkg::*;
#(
    parameter  int EXP_W = FP_EXP_W,
    parameter  int MAN_W = FP_MAN_W,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         of,
    output logic         uf,
    output logic         nv
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = $clog2(SIG_W + 1);
    localparam int XW     = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);

    fp_state_e            r_state;
    fp_state_e            w_next;
    logic                 r_armed;
    logic [CNT_W-1:0]     r_cnt;
    logic [SIG_W-1:0]     r_mcand;
    logic [PROD_W-1:0]    r_prod;
    logic signed [XW-1:0] r_exp;
    logic                 r_sign;
    logic [W-1:0]         r_result;
    logic                 r_of;
    logic                 r_uf;
    logic                 r_nv;

    logic                 w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]     w_ea, w_eb;
    logic [MAN_W-1:0]     w_fa, w_fb;
    logic                 w_a_ones, w_b_ones, w_a_zero, w_b_zero;
    logic                 w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic                 w_special;
    logic                 w_accept;
    logic [W-1:0]         w_spec_res;
    logic                 w_spec_nv;
    logic [SIG_W-1:0]     w_addend;
    logic [SIG_W:0]       w_sum;
    logic [W-1:0]         w_rn_result;
    logic                 w_rn_of;
    logic                 w_rn_uf;

    assign {w_sa, w_ea, w_fa} = op_a;
    assign {w_sb, w_eb, w_fb} = op_b;
    assign w_sign   = w_sa ^ w_sb;
    assign w_accept = in_valid & in_ready;

    assign w_a_ones  = fp_exp_ones(FP_MAXW'(w_ea), EXP_W);
    assign w_b_ones  = fp_exp_ones(FP_MAXW'(w_eb), EXP_W);
    assign w_a_zero  = fp_exp_zero(FP_MAXW'(w_ea));
    assign w_b_zero  = fp_exp_zero(FP_MAXW'(w_eb));
    assign w_a_nan   = w_a_ones & (|w_fa);
    assign w_b_nan   = w_b_ones & (|w_fb);
    assign w_a_inf   = w_a_ones & ~(|w_fa);
    assign w_b_inf   = w_b_ones & ~(|w_fb);
    assign w_special = w_a_ones | w_b_ones | w_a_zero | w_b_zero;

    // Denormal inputs are flushed: any exp==0 operand counts as a signed zero.
    always_comb begin
        w_spec_res = '0;
        w_spec_nv  = 1'b0;
        if (w_a_nan | w_b_nan) begin
            w_spec_res = W'(fp_qnan(EXP_W, MAN_W));
        end else if ((w_a_zero & w_b_inf) | (w_a_inf & w_b_zero)) begin
            w_spec_res = W'(fp_qnan(EXP_W, MAN_W));
            w_spec_nv  = 1'b1;
        end else if (w_a_inf | w_b_inf) begin
            w_spec_res = W'(fp_inf(w_sign, EXP_W, MAN_W));
        end else begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end
    end

    // Upper half accumulates, lower half shifts the multiplier out LSB first.
    assign w_addend = r_prod[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_prod[PROD_W-1:SIG_W]} + {1'b0, w_addend};

    fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_norm (
        .i_prod   (r_prod),
        .i_exp    (r_exp),
        .i_sign   (r_sign),
        .o_result (w_rn_result),
        .o_of     (w_rn_of),
        .o_uf     (w_rn_uf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_special ? DONE : MUL;
            MUL:     if (r_cnt == CNT_W'(SIG_W - 1)) w_next = NORM;
            NORM:    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // r_armed holds off in_ready until the first edge after reset release.
    always_comb begin
        in_ready  = (r_state == IDLE) & r_armed;
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed  <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_of     <= 1'b0;
            r_uf     <= 1'b0;
            r_nv     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign  <= w_sign;
                        r_exp   <= XW'(w_ea) + XW'(w_eb) - BIAS;
                        r_mcand <= {1'b1, w_fa};
                        r_prod  <= {{SIG_W{1'b0}}, 1'b1, w_fb};
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_result <= w_spec_res;
                            r_nv     <= w_spec_nv;
                            r_of     <= 1'b0;
                            r_uf     <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    r_prod <= {w_sum, r_prod[SIG_W-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                NORM: begin
                    r_result <= w_rn_result;
                    r_of     <= w_rn_of;
                    r_uf     <= w_rn_uf;
                    r_nv     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign of     = r_of;
    assign uf     = r_uf;
    assign nv     = r_nv;

endmodule

// File: tb/tb_fp_seq_multiplier.sv
// Directed and randomized checks of fp_seq_multiplier (binary32 configuration)
// against a numeric reference model of IEEE-style multiplication.
module tb_fp_seq_multiplier;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         of, uf, nv;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fp_seq_multiplier #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .of        (of),
        .uf        (uf),
        .nv        (nv)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {special, nv, of, uf, result}; computed from real-valued rules.
    function automatic logic [35:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        logic [22:0] fa, fb;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned sa, sb, p, m, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return {4'b1000, 32'h7FC00000};
        if ((a_zero && b_inf) || (a_inf && b_zero)) return {4'b1100, 32'h7FC00000};
        if (a_inf || b_inf) return {4'b1000, s, 8'hFF, 23'h0};
        if (a_zero || b_zero) return {4'b1000, s, 31'h0};
        sa   = 64'h800000 + 64'(fa);
        sb   = 64'h800000 + 64'(fb);
        p    = sa * sb;
        sh   = ((p >> 47) != 0) ? 24 : 23;
        e    = ea + eb - 127 + (sh - 23);
        m    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && m[0])) m = m + 1;
        if (m == 64'h1000000) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0001, s, 31'h0};
        return {4'b0000, s, e[7:0], m[22:0]};
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (in_ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    // Counts falling edges after the accepting edge until out_valid shows.
    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic run_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [2:0] ef, input int el);
        int lat;
        launch(a, b);
        wait_out(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_flags"}, 64'({nv, of, uf}), 64'(ef));
        @(negedge clk);
        chk({tag, "_xfer"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        logic [35:0] m;
        logic [31:0] a, b;
        int lat, hi;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_a = '0; op_b = '0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_flags", 64'({nv, of, uf}), 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rdy_before_edge", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("rdy_after_edge", 64'(in_ready), 64'(1));

        // {nv,of,uf} flag order in the expectations below
        run_exp("mul_2x3p5",  32'h40000000, 32'h40600000, 32'h40E00000, 3'b000, 26);
        run_exp("mul_neg",    32'hC0000000, 32'hC0A00000, 32'h41200000, 3'b000, 26);
        run_exp("mul_one",    32'h3F800000, 32'h41C80000, 32'h41C80000, 3'b000, 26);
        run_exp("mul_round",  32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 26);
        run_exp("zero_x_inf", 32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b100, 1);
        run_exp("nan_in",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000, 1);
        run_exp("overflow",   32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 26);
        run_exp("underflow",  32'h00800000, 32'h3F000000, 32'h00000000, 3'b001, 26);
        run_exp("ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1);
        run_exp("nzero_x_2",  32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 1);
        run_exp("denorm_ftz", 32'h00400000, 32'hC0000000, 32'h80000000, 3'b000, 1);

        out_ready = 1'b0;
        launch(32'h40000000, 32'h40600000);
        wait_out(lat);
        chk("bp_lat", 64'(lat), 64'(26));
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            op_a     = $urandom;
            op_b     = $urandom;
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
            chk("bp_hold_res", 64'(result), 64'(32'h40E00000));
            chk("bp_hold_flags", 64'({nv, of, uf}), 64'(0));
            chk("bp_hold_rdy", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_xfer", 64'(out_valid), 64'(0));
        chk("bp_idle_rdy", 64'(in_ready), 64'(1));

        launch(32'h40400000, 32'h3FC00000);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'(0));
        chk("abort_rdy", 64'(in_ready), 64'(0));
        chk("abort_res", 64'(result), 64'(0));
        chk("abort_flags", 64'({nv, of, uf}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) hi++;
        end
        chk("abort_no_out", 64'(hi), 64'(0));
        run_exp("after_abort", 32'h40400000, 32'h40400000, 32'h41100000, 3'b000, 26);

        for (int i = 0; i < 40; i++) begin
            int cat;
            cat = int'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (cat < 5) begin
                a[30:23] = 8'($urandom_range(100, 154));
                b[30:23] = 8'($urandom_range(100, 154));
            end else if (cat == 5) begin
                a[30:23] = 8'($urandom_range(190, 254));
                b[30:23] = 8'($urandom_range(120, 200));
            end else if (cat == 6) begin
                a[30:23] = 8'($urandom_range(1, 60));
                b[30:23] = 8'($urandom_range(1, 80));
            end else begin
                a[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            end
            m = fp_model(a, b);
            run_exp("rand", a, b, m[31:0], m[34:32], m[35] ? 1 : 26);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
